cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Control sequencer for the simple CPU datapath. It runs the fetch/decode/execute state machine and drives the `load`/`inc` command pairs that every datapath register (PC, AR, DR, IR, AC, R, Z) obeys. It also drives the internal bus source select, the ALU op, and a ready-handshaked memory read/write interface. It issues the commands that the registers consume.

## Interface
- `OPW`, default 4: opcode width taken from IR.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `ir_op` in OPW: current IR opcode field.
- `z` in 1: Z flag register output.
- `mem_ready` in 1: memory completes the current `mem_rd`/`mem_wr` this cycle.
- `pc_load`, `pc_inc`, `ar_load`, `dr_load`, `ir_load`, `ac_load`, `ac_inc`, `r_load`, `z_load` out 1 each: register commands.
- `bus_sel` out 3: bus source. 0 none, 1 PC, 2 DR, 3 AC, 4 R, 5 MEM.
- `alu_op` out 2: 0 pass bus, 1 AC+R, 2 clear.
- `mem_rd`, `mem_wr` out 1: memory strobes, held until `mem_ready`.
- `halted` out 1: in HALT state.
- `illegal` out 1: sticky illegal-opcode flag (see Configuration).

## Operation
- Moore FSM. Outputs decode from state, except the `mem_ready`-qualified loads. Unlisted outputs are 0.
- **FETCH1**: `bus_sel`=PC, `ar_load`.
- **FETCH2**: `mem_rd`. When `mem_ready`: `bus_sel`=MEM, `dr_load`, `pc_inc`, go to FETCH3. Otherwise stay.
- **FETCH3**: `bus_sel`=DR, `ir_load`.
- **DECODE**: `bus_sel`=PC, `ar_load`. Branches on `ir_op`:
  - 0 NOP → FETCH1.
  - 1 LDAC, 2 STAC, 3 JUMP → ADR1.
  - 4 JMPZ → ADR1 if `z`=1, else SKIP.
  - 5 ADD → EXADD.
  - 6 INC → EXINC.
  - 7 CLAC → EXCLR.
  - 8 HALT → HALT.
  - 9 MVAC → EXMV.
  - 10–15: illegal.
- **ADR1**: `mem_rd`. When `mem_ready`: `bus_sel`=MEM, `dr_load`, `pc_inc`. Then LDAC/STAC → ADR2; JUMP/JMPZ → JMP2.
- **ADR2**: `bus_sel`=DR, `ar_load`. Then LDAC → LD3; STAC → ST3.
- **LD3**: `mem_rd`. When `mem_ready`: `bus_sel`=MEM, `dr_load`, go to LD4.
- **LD4**: `bus_sel`=DR, `ac_load`, `alu_op`=0 → FETCH1.
- **ST3**: `bus_sel`=AC, `mem_wr` until `mem_ready` → FETCH1.
- **JMP2**: `bus_sel`=DR, `pc_load` → FETCH1.
- **SKIP**: `pc_inc` → FETCH1. Steps PC over the operand byte.
- **EXADD**: `bus_sel`=R, `alu_op`=1, `ac_load`, `z_load` → FETCH1.
- **EXINC**: `ac_inc`, `z_load` → FETCH1.
- **EXCLR**: `alu_op`=2, `ac_load`, `z_load` → FETCH1.
- **EXMV**: `bus_sel`=AC, `r_load` → FETCH1.
- **HALT**: `halted`=1. Absorbing until `rst`.
- Invariants, every cycle:
  - never `X_load` and `X_inc` together for the same register;
  - never `mem_rd` and `mem_wr` together;
  - any bus-sourced load has a nonzero `bus_sel`.

## Timing
- Reset: while `rst`=1 all outputs are 0, including `halted` and `illegal`. The state is FETCH1 on the first cycle after `rst` falls.
- Reset mid-operation, including during a pending memory wait: strobes drop in the `rst` cycle and there is no further command. Execution restarts at FETCH1.
- With `mem_ready` tied to 1, cycle counts from FETCH1 to the next FETCH1 are:
  - NOP 4;
  - ADD, INC, CLAC, MVAC 5;
  - JUMP, and JMPZ taken, 6;
  - JMPZ not taken 5;
  - STAC 7;
  - LDAC 8.
- Each cycle `mem_ready` is low in a memory state adds exactly one cycle. The state and strobes are held constant during the wait.
- `mem_ready` outside a memory state is ignored.
- `z` is sampled only in DECODE.

## Configuration
- `CPU_CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT and sets `illegal`=1 (sticky until `rst`).
- `CPU_CTRL_ILLEGAL_TRAP_EN` undefined: an illegal opcode behaves exactly as NOP, and `illegal` is tied to 0.

## Test plan
- Reset, then `mem_ready`=1, memory returns 0x0 (NOP) → FETCH1 `ar_load`+`bus_sel`=1, then `mem_rd`/`dr_load`/`pc_inc`, then `ir_load`, then DECODE. Repeats every 4 cycles; `pc_inc` pulses once per 4 cycles.
- LDAC with `mem_ready` low 3 cycles on LD3 → `mem_rd` held 4 cycles with no `dr_load` until ready. `ac_load` occurs 11 cycles after FETCH1; the `pc_inc` count over the instruction is 2.
- JMPZ with `z`=0 → SKIP asserts `pc_inc`, no `pc_load`, 5 cycles. With `z`=1 → `pc_load` with `bus_sel`=2 in cycle 6.
- `rst` asserted in ST3 while `mem_wr`=1, `mem_ready`=0 → all outputs 0 in that cycle. FETCH1 outputs appear one cycle after `rst` falls; no `mem_wr` reappears.
- Opcode 0xC, with and without `CPU_CTRL_ILLEGAL_TRAP_EN` → defined: `halted`=1 and `illegal`=1 from the cycle after DECODE, persisting 100 cycles. Undefined: next FETCH1 after 4 cycles, `illegal`=0.
- Random opcodes and random `mem_ready` for 10k cycles → the load/inc, rd/wr and bus invariants hold every cycle.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_seq
//   Fetch/decode/execute control sequencer for the simple CPU datapath.
//   Drives the load/inc command pairs of PC, AR, DR, IR, AC, R and Z, the
//   internal bus source select, the ALU operation and a ready-handshaked
//   memory read/write interface.
//
// Parameters
//   OPW        opcode width of the IR opcode field (default 4)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   ir_op      in   [OPW-1:0] current IR opcode field
//   z          in   Z flag register output (sampled in DECODE only)
//   mem_ready  in   memory completes the pending mem_rd/mem_wr this cycle
//   pc_load, pc_inc, ar_load, dr_load, ir_load,
//   ac_load, ac_inc, r_load, z_load            out  register commands
//   bus_sel    out  [2:0] 0 none, 1 PC, 2 DR, 3 AC, 4 R, 5 MEM
//   alu_op     out  [1:0] 0 pass bus, 1 AC+R, 2 clear
//   mem_rd, mem_wr  out  memory strobes, held until mem_ready
//   halted     out  machine is in HALT
//   illegal    out  sticky illegal-opcode flag
//
// Configuration macro
//   CPU_CTRL_ILLEGAL_TRAP_EN  defined: illegal opcode halts and sets the
//                             sticky illegal flag. Undefined: illegal
//                             opcodes act as NOP and illegal is 0.
// ---------------------------------------------------------------------------
module cpu_ctrl_seq #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] ir_op,
    input  logic           z,
    input  logic           mem_ready,
    output logic           pc_load,
    output logic           pc_inc,
    output logic           ar_load,
    output logic           dr_load,
    output logic           ir_load,
    output logic           ac_load,
    output logic           ac_inc,
    output logic           r_load,
    output logic           z_load,
    output logic [2:0]     bus_sel,
    output logic [1:0]     alu_op,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           halted,
    output logic           illegal
);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_LDAC = OPW'(1);
    localparam logic [OPW-1:0] OP_STAC = OPW'(2);
    localparam logic [OPW-1:0] OP_JUMP = OPW'(3);
    localparam logic [OPW-1:0] OP_JMPZ = OPW'(4);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5);
    localparam logic [OPW-1:0] OP_INC  = OPW'(6);
    localparam logic [OPW-1:0] OP_CLAC = OPW'(7);
    localparam logic [OPW-1:0] OP_HALT = OPW'(8);
    localparam logic [OPW-1:0] OP_MVAC = OPW'(9);

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_DR   = 3'd2;
    localparam logic [2:0] BUS_AC   = 3'd3;
    localparam logic [2:0] BUS_R    = 3'd4;
    localparam logic [2:0] BUS_MEM  = 3'd5;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_CLR  = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH1 = 4'd0,
        ST_FETCH2 = 4'd1,
        ST_FETCH3 = 4'd2,
        ST_DECODE = 4'd3,
        ST_ADR1   = 4'd4,
        ST_ADR2   = 4'd5,
        ST_LD3    = 4'd6,
        ST_LD4    = 4'd7,
        ST_ST3    = 4'd8,
        ST_JMP2   = 4'd9,
        ST_SKIP   = 4'd10,
        ST_EXADD  = 4'd11,
        ST_EXINC  = 4'd12,
        ST_EXCLR  = 4'd13,
        ST_EXMV   = 4'd14,
        ST_HALT   = 4'd15
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   illegal_flag_s;

    // Opcodes above MVAC have no defined behaviour.
    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return (op <= OP_MVAC);
    endfunction

    // State register; reset restarts execution at FETCH1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH1;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic trap_r;

    // Sticky trap flag, set when DECODE meets an undefined opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else if ((state_r == ST_DECODE) && !op_is_legal(ir_op)) begin
            trap_r <= 1'b1;
        end else begin
            trap_r <= trap_r;
        end
    end

    assign illegal_flag_s = trap_r;
`else
    assign illegal_flag_s = 1'b0;
`endif

    // Next-state logic; memory states wait in place until mem_ready.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH1: next_state_s = ST_FETCH2;
            ST_FETCH2: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH3;
                end else begin
                    next_state_s = ST_FETCH2;
                end
            end
            ST_FETCH3: next_state_s = ST_DECODE;
            ST_DECODE: begin
                case (ir_op)
                    OP_NOP:  next_state_s = ST_FETCH1;
                    OP_LDAC: next_state_s = ST_ADR1;
                    OP_STAC: next_state_s = ST_ADR1;
                    OP_JUMP: next_state_s = ST_ADR1;
                    OP_JMPZ: begin
                        if (z) begin
                            next_state_s = ST_ADR1;
                        end else begin
                            next_state_s = ST_SKIP;
                        end
                    end
                    OP_ADD:  next_state_s = ST_EXADD;
                    OP_INC:  next_state_s = ST_EXINC;
                    OP_CLAC: next_state_s = ST_EXCLR;
                    OP_HALT: next_state_s = ST_HALT;
                    OP_MVAC: next_state_s = ST_EXMV;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    default: next_state_s = ST_HALT;
`else
                    default: next_state_s = ST_FETCH1;
`endif
                endcase
            end
            ST_ADR1: begin
                if (!mem_ready) begin
                    next_state_s = ST_ADR1;
                end else if ((ir_op == OP_LDAC) || (ir_op == OP_STAC)) begin
                    next_state_s = ST_ADR2;
                end else begin
                    next_state_s = ST_JMP2;
                end
            end
            ST_ADR2: begin
                if (ir_op == OP_LDAC) begin
                    next_state_s = ST_LD3;
                end else begin
                    next_state_s = ST_ST3;
                end
            end
            ST_LD3: begin
                if (mem_ready) begin
                    next_state_s = ST_LD4;
                end else begin
                    next_state_s = ST_LD3;
                end
            end
            ST_LD4:   next_state_s = ST_FETCH1;
            ST_ST3: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH1;
                end else begin
                    next_state_s = ST_ST3;
                end
            end
            ST_JMP2:  next_state_s = ST_FETCH1;
            ST_SKIP:  next_state_s = ST_FETCH1;
            ST_EXADD: next_state_s = ST_FETCH1;
            ST_EXINC: next_state_s = ST_FETCH1;
            ST_EXCLR: next_state_s = ST_FETCH1;
            ST_EXMV:  next_state_s = ST_FETCH1;
            ST_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_FETCH1;
        endcase
    end

    // Output decode. Everything is forced low while rst is high so a pending
    // memory strobe drops in the reset cycle itself. The memory-state loads
    // are qualified by mem_ready; the strobes are held during the wait.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        ar_load = 1'b0;
        dr_load = 1'b0;
        ir_load = 1'b0;
        ac_load = 1'b0;
        ac_inc  = 1'b0;
        r_load  = 1'b0;
        z_load  = 1'b0;
        bus_sel = BUS_NONE;
        alu_op  = ALU_PASS;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        if (rst) begin
            illegal = 1'b0;
        end else begin
            illegal = illegal_flag_s;
            case (state_r)
                ST_FETCH1, ST_DECODE: begin
                    bus_sel = BUS_PC;
                    ar_load = 1'b1;
                end
                ST_FETCH2, ST_ADR1: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        bus_sel = BUS_MEM;
                        dr_load = 1'b1;
                        pc_inc  = 1'b1;
                    end else begin
                        bus_sel = BUS_NONE;
                    end
                end
                ST_FETCH3: begin
                    bus_sel = BUS_DR;
                    ir_load = 1'b1;
                end
                ST_ADR2: begin
                    bus_sel = BUS_DR;
                    ar_load = 1'b1;
                end
                ST_LD3: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        bus_sel = BUS_MEM;
                        dr_load = 1'b1;
                    end else begin
                        bus_sel = BUS_NONE;
                    end
                end
                ST_LD4: begin
                    bus_sel = BUS_DR;
                    alu_op  = ALU_PASS;
                    ac_load = 1'b1;
                end
                ST_ST3: begin
                    bus_sel = BUS_AC;
                    mem_wr  = 1'b1;
                end
                ST_JMP2: begin
                    bus_sel = BUS_DR;
                    pc_load = 1'b1;
                end
                ST_SKIP: pc_inc = 1'b1;
                ST_EXADD: begin
                    bus_sel = BUS_R;
                    alu_op  = ALU_ADD;
                    ac_load = 1'b1;
                    z_load  = 1'b1;
                end
                ST_EXINC: begin
                    ac_inc = 1'b1;
                    z_load = 1'b1;
                end
                ST_EXCLR: begin
                    alu_op  = ALU_CLR;
                    ac_load = 1'b1;
                    z_load  = 1'b1;
                end
                ST_EXMV: begin
                    bus_sel = BUS_AC;
                    r_load  = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_seq
//   Directed self-checking bench for cpu_ctrl_seq. Each cycle the full output
//   word is compared with a hand-computed constant, followed by a random
//   phase that counts invariant violations.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ir_op;
    logic       z;
    logic       mem_ready;
    logic       pc_load, pc_inc, ar_load, dr_load, ir_load;
    logic       ac_load, ac_inc, r_load, z_load;
    logic [2:0] bus_sel;
    logic [1:0] alu_op;
    logic       mem_rd, mem_wr, halted, illegal;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int pc_inc_cnt = 0;
    int viol_cnt   = 0;

    // Output word: {pc_load,pc_inc,ar_load,dr_load,ir_load,ac_load,ac_inc,
    //               r_load,z_load, bus_sel[2:0], alu_op[1:0],
    //               mem_rd, mem_wr, halted, illegal}
    logic [17:0] outs_s;
    assign outs_s = {pc_load, pc_inc, ar_load, dr_load, ir_load, ac_load, ac_inc,
                     r_load, z_load, bus_sel, alu_op, mem_rd, mem_wr, halted, illegal};

    localparam logic [17:0] ZERO  = 18'd0;
    localparam logic [17:0] F1    = {9'b001000000, 3'd1, 2'd0, 4'b0000};
    localparam logic [17:0] RD_OK = {9'b010100000, 3'd5, 2'd0, 4'b1000};
    localparam logic [17:0] RD_WT = {9'b000000000, 3'd0, 2'd0, 4'b1000};
    localparam logic [17:0] F3    = {9'b000010000, 3'd2, 2'd0, 4'b0000};
    localparam logic [17:0] ADR2  = {9'b001000000, 3'd2, 2'd0, 4'b0000};
    localparam logic [17:0] LD3OK = {9'b000100000, 3'd5, 2'd0, 4'b1000};
    localparam logic [17:0] LD4   = {9'b000001000, 3'd2, 2'd0, 4'b0000};
    localparam logic [17:0] ST3   = {9'b000000000, 3'd3, 2'd0, 4'b0100};
    localparam logic [17:0] JMP2  = {9'b100000000, 3'd2, 2'd0, 4'b0000};
    localparam logic [17:0] SKIP  = {9'b010000000, 3'd0, 2'd0, 4'b0000};
    localparam logic [17:0] EXADD = {9'b000001001, 3'd4, 2'd1, 4'b0000};
    localparam logic [17:0] EXINC = {9'b000000101, 3'd0, 2'd0, 4'b0000};
    localparam logic [17:0] EXCLR = {9'b000001001, 3'd0, 2'd2, 4'b0000};
    localparam logic [17:0] EXMV  = {9'b000000010, 3'd3, 2'd0, 4'b0000};
    localparam logic [17:0] HALTV = {9'b000000000, 3'd0, 2'd0, 4'b0010};
    localparam logic [17:0] TRAPV = {9'b000000000, 3'd0, 2'd0, 4'b0011};

    cpu_ctrl_seq #(.OPW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ir_op     (ir_op),
        .z         (z),
        .mem_ready (mem_ready),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .ar_load   (ar_load),
        .dr_load   (dr_load),
        .ir_load   (ir_load),
        .ac_load   (ac_load),
        .ac_inc    (ac_inc),
        .r_load    (r_load),
        .z_load    (z_load),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
        .illegal   (illegal)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Invariant monitor, sampled on the falling edge every cycle.
    always @(negedge clk) begin
        if ((pc_load && pc_inc) || (ac_load && ac_inc) || (mem_rd && mem_wr) ||
            ((pc_load || ar_load || dr_load || ir_load || r_load ||
              (ac_load && (alu_op != 2'd2))) && (bus_sel == 3'd0))) begin
            viol_cnt <= viol_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance.
    task automatic cyc(input string tag, input logic r, input logic rdy,
                       input logic [17:0] exp);
        rst       = r;
        mem_ready = rdy;
        #1;
        check(tag, {14'd0, outs_s}, {14'd0, exp});
        pc_inc_cnt += int'(pc_inc);
        @(posedge clk);
        #1;
    endtask

    // FETCH1..DECODE with memory always ready.
    task automatic fetch(input logic [3:0] op);
        ir_op = op;
        cyc("fetch1", 1'b0, 1'b1, F1);
        cyc("fetch2", 1'b0, 1'b1, RD_OK);
        cyc("fetch3", 1'b0, 1'b1, F3);
        cyc("decode", 1'b0, 1'b1, F1);
    endtask

    initial begin
        rst = 1'b1; ir_op = 4'd0; z = 1'b0; mem_ready = 1'b0;

        // Reset: all outputs low.
        cyc("reset0", 1'b1, 1'b0, ZERO);
        cyc("reset1", 1'b1, 1'b1, ZERO);

        // Two NOPs back to back: 4 cycles each, one pc_inc each.
        pc_inc_cnt = 0;
        fetch(4'd0);
        fetch(4'd0);
        check("nop_pcinc", pc_inc_cnt, 2);

        // LDAC with a fetch wait and three LD3 wait cycles.
        pc_inc_cnt = 0;
        ir_op = 4'd1;
        cyc("ld_f1", 1'b0, 1'b1, F1);
        cyc("ld_f2w", 1'b0, 1'b0, RD_WT);
        cyc("ld_f2", 1'b0, 1'b1, RD_OK);
        cyc("ld_f3", 1'b0, 1'b1, F3);
        cyc("ld_dec", 1'b0, 1'b1, F1);
        cyc("ld_adr1", 1'b0, 1'b1, RD_OK);
        cyc("ld_adr2", 1'b0, 1'b1, ADR2);
        cyc("ld3_w0", 1'b0, 1'b0, RD_WT);
        cyc("ld3_w1", 1'b0, 1'b0, RD_WT);
        cyc("ld3_w2", 1'b0, 1'b0, RD_WT);
        cyc("ld3_ok", 1'b0, 1'b1, LD3OK);
        cyc("ld4", 1'b0, 1'b1, LD4);
        check("ldac_pcinc", pc_inc_cnt, 2);

        // STAC: 7 cycles.
        fetch(4'd2);
        cyc("st_adr1", 1'b0, 1'b1, RD_OK);
        cyc("st_adr2", 1'b0, 1'b1, ADR2);
        cyc("st3", 1'b0, 1'b1, ST3);

        // JUMP: 6 cycles.
        fetch(4'd3);
        cyc("jmp_adr1", 1'b0, 1'b1, RD_OK);
        cyc("jmp2", 1'b0, 1'b1, JMP2);

        // JMPZ not taken; z high outside DECODE must not matter.
        z = 1'b0;
        fetch(4'd4);
        z = 1'b1;
        cyc("jmpz_skip", 1'b0, 1'b1, SKIP);

        // JMPZ taken; z dropped after DECODE must not matter.
        z = 1'b1;
        fetch(4'd4);
        z = 1'b0;
        cyc("jmpz_adr1", 1'b0, 1'b1, RD_OK);
        cyc("jmpz_jmp2", 1'b0, 1'b1, JMP2);

        // ALU/move instructions; mem_ready low outside memory states ignored.
        fetch(4'd5);
        cyc("exadd", 1'b0, 1'b0, EXADD);
        fetch(4'd6);
        cyc("exinc", 1'b0, 1'b0, EXINC);
        fetch(4'd7);
        cyc("exclr", 1'b0, 1'b1, EXCLR);
        fetch(4'd9);
        cyc("exmv", 1'b0, 1'b0, EXMV);

        // Reset during a pending store.
        fetch(4'd2);
        cyc("rs_adr1", 1'b0, 1'b1, RD_OK);
        cyc("rs_adr2", 1'b0, 1'b1, ADR2);
        cyc("rs_st3w", 1'b0, 1'b0, ST3);
        cyc("rs_rst", 1'b1, 1'b0, ZERO);
        ir_op = 4'd0;
        cyc("rs_f1", 1'b0, 1'b1, F1);
        cyc("rs_f2", 1'b0, 1'b1, RD_OK);
        cyc("rs_f3", 1'b0, 1'b1, F3);
        cyc("rs_dec", 1'b0, 1'b1, F1);

        // HALT is absorbing, mem_ready ignored.
        fetch(4'd8);
        for (int i = 0; i < 5; i++) begin
            cyc("halt", 1'b0, i[0], HALTV);
        end
        cyc("halt_rst", 1'b1, 1'b0, ZERO);

        // Opcode 0xC.
        fetch(4'hC);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ir_op = 4'd0;
        for (int i = 0; i < 100; i++) begin
            cyc("trap", 1'b0, 1'b1, TRAPV);
        end
        cyc("trap_rst", 1'b1, 1'b0, ZERO);
        cyc("trap_f1", 1'b0, 1'b1, F1);
`else
        cyc("ill_f1", 1'b0, 1'b1, F1);
        cyc("ill_f2", 1'b0, 1'b1, RD_OK);
`endif
        cyc("pre_rand", 1'b1, 1'b0, ZERO);

        // Random phase with periodic reset.
        for (int i = 0; i < 10000; i++) begin
            rst       = ((i % 250) == 0);
            ir_op     = 4'($urandom_range(0, 15));
            z         = 1'($urandom);
            mem_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("invariants", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
